// File: rtl/track_recorder_pkg.sv
// Shared note-track constants and recorder state encoding.
// The playback side imports the same depth and width constants.
package track_recorder_pkg;

  localparam int TRK_LANES  = 4;
  localparam int TRK_DEPTH  = 32;
  localparam int TRK_ADDR_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_RECORD = 2'd2,
    ST_DONE   = 2'd3
  } rec_state_t;

endpackage

// File: rtl/track_recorder_sync_edge.sv
// Two-flop synchroniser for an asynchronous level, followed by a registered
// rising-edge detect that yields a one-cycle pulse per edge.
module sync_edge (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_rise
);

  logic r_meta;
  logic r_sync;
  logic r_prev;
  logic r_rise;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
      r_rise <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_prev <= r_sync;
      r_rise <= r_sync & ~r_prev;
    end
  end

  assign o_rise = r_rise;

endmodule

// File: rtl/track_recorder.sv
// Records one LANES-bit word of lane presses per game beat into the track RAM,
// driving the RAM write port (ADDRESS/DATA/WREN) directly.
module track_recorder
  import track_recorder_pkg::*;
#(
  parameter int ADDR_W = TRK_ADDR_W,
  parameter int DEPTH  = TRK_DEPTH,
  parameter int LANES  = TRK_LANES
) (
  input  logic              CLOCK_50,
  input  logic              RESET_GAME,
  input  logic              START,
  input  logic              ABORT,
  input  logic              BEAT,
  input  logic [LANES-1:0]  LANE_IN,
  output logic [ADDR_W-1:0] ADDRESS,
  output logic [LANES-1:0]  DATA,
  output logic              WREN,
  output logic              BUSY,
  output logic              DONE
);

  rec_state_t        r_state;
  rec_state_t        w_state_nxt;
  logic [ADDR_W-1:0] r_slot;
  logic [ADDR_W-1:0] w_slot_nxt;
  logic [LANES-1:0]  r_latch;
  logic [LANES-1:0]  w_latch_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic [LANES-1:0]  r_data;
  logic [LANES-1:0]  w_data_nxt;
  logic              r_wren;
  logic              w_wren_nxt;

  logic [LANES-1:0]  r_lane_meta;
  logic [LANES-1:0]  r_lane_sync;
  logic              w_beat_rise;
  logic [LANES-1:0]  w_slot_word;
  logic              w_last_slot;

  sync_edge u_beat_sync (
    .i_clk   (CLOCK_50),
    .i_rst   (RESET_GAME),
    .i_async (BEAT),
    .o_rise  (w_beat_rise)
  );

  always_ff @(posedge CLOCK_50) begin
    if (RESET_GAME) begin
      r_lane_meta <= '0;
      r_lane_sync <= '0;
    end else begin
      r_lane_meta <= LANE_IN;
      r_lane_sync <= r_lane_meta;
    end
  end

  // Presses still visible in the beat_rise cycle belong to the slot being closed.
  assign w_slot_word = r_latch | r_lane_sync;
  assign w_last_slot = (r_slot == ADDR_W'(DEPTH - 1));

  always_comb begin
    w_state_nxt = r_state;
    w_slot_nxt  = r_slot;
    w_latch_nxt = r_latch;
    w_addr_nxt  = r_addr;
    w_data_nxt  = r_data;
    w_wren_nxt  = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_latch_nxt = '0;
        if (START) begin
          w_state_nxt = ST_ARMED;
          w_slot_nxt  = '0;
        end
      end
      ST_ARMED: begin
        w_latch_nxt = '0;
        if (w_beat_rise) begin
          w_state_nxt = ST_RECORD;
          w_slot_nxt  = '0;
        end
      end
      ST_RECORD: begin
        w_latch_nxt = w_slot_word;
        if (w_beat_rise) begin
          w_data_nxt  = w_slot_word;
          w_addr_nxt  = r_slot;
          w_wren_nxt  = 1'b1;
          w_latch_nxt = '0;
          if (w_last_slot) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_slot_nxt = r_slot + ADDR_W'(1);
          end
        end
      end
      ST_DONE: begin
        w_latch_nxt = '0;
        if (START) begin
          w_state_nxt = ST_ARMED;
          w_slot_nxt  = '0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_latch_nxt = '0;
      end
    endcase

    // Abort overrides any transition or write decided above.
    if (ABORT) begin
      w_state_nxt = ST_IDLE;
      w_latch_nxt = '0;
      w_addr_nxt  = r_addr;
      w_data_nxt  = r_data;
      w_wren_nxt  = 1'b0;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET_GAME) begin
      r_state <= ST_IDLE;
      r_slot  <= '0;
      r_latch <= '0;
      r_addr  <= '0;
      r_data  <= '0;
      r_wren  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_slot  <= w_slot_nxt;
      r_latch <= w_latch_nxt;
      r_addr  <= w_addr_nxt;
      r_data  <= w_data_nxt;
      r_wren  <= w_wren_nxt;
    end
  end

  assign ADDRESS = r_addr;
  assign DATA    = r_data;
  assign WREN    = r_wren;
  assign BUSY    = (r_state == ST_ARMED) || (r_state == ST_RECORD);
  assign DONE    = (r_state == ST_DONE);

endmodule
